// File: rtl/muldiv_if.sv
// muldiv_if: issue/writeback handshake between the core and the iterative RV32M unit
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [3:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        busy;
  logic        wreq;
  logic [3:0]  windex;
  logic [31:0] wdata;
  modport master (output start, funct3, rd, rs1_val, rs2_val, input busy, wreq, windex, wdata);
  modport slave (input start, funct3, rd, rs1_val, rs2_val, output busy, wreq, windex, wdata);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-iteration shift-add multiply / restoring divide on operand magnitudes, sign fixed in DONE
module muldiv_seq (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  rd_q, rd_d, windex_q, windex_d;
  logic [31:0] b_q, b_d, wdata_q, wdata_d;
  logic [63:0] acc_q, acc_d;
  logic        sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
  logic        sa, sb, busy, wreq;
  logic [31:0] ma, mb, quo, rem, res;
  logic [32:0] msum, dtrial;
  logic [63:0] prod;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      dz_q     <= 1'b0;
      windex_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      dz_q     <= dz_d;
      windex_q <= windex_d;
      wdata_q  <= wdata_d;
    end
  // acc holds {hi, multiplier} for multiply and {remainder, dividend->quotient} for divide
  always_comb begin
    sa     = (bus.funct3[2] ? !bus.funct3[0] : bus.funct3[1:0] != 2'b11) && bus.rs1_val[31];
    sb     = (bus.funct3[2] ? !bus.funct3[0] : !bus.funct3[1]) && bus.rs2_val[31];
    ma     = sa ? -bus.rs1_val : bus.rs1_val;
    mb     = sb ? -bus.rs2_val : bus.rs2_val;
    msum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    dtrial = acc_q[63:31] - {1'b0, b_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;
    if (state_q == IDLE && bus.start) begin
      state_d = CALC;
      cnt_d   = '0;
      op_d    = bus.funct3;
      rd_d    = bus.rd;
      b_d     = bus.funct3[2] ? mb : ma;
      acc_d   = {32'd0, bus.funct3[2] ? ma : mb};
      sq_d    = sa ^ sb;
      sr_d    = sa;
      dz_d    = bus.rs2_val == '0;
    end
    if (state_q == CALC) begin
      cnt_d   = cnt_q + 5'd1;
      acc_d   = op_q[2] ? (dtrial[32] ? {acc_q[62:0], 1'b0} : {dtrial[31:0], acc_q[30:0], 1'b1})
                        : {msum, acc_q[31:1]};
      state_d = cnt_q == 5'd31 ? DONE : CALC;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_comb begin
    prod     = sq_q ? -acc_q : acc_q;
    quo      = dz_q ? '1 : (sq_q ? -acc_q[31:0] : acc_q[31:0]);
    rem      = sr_q ? -acc_q[63:32] : acc_q[63:32];
    res      = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
    busy     = state_q != IDLE;
    wreq     = state_q == DONE && rd_q != '0;
    windex_d = wreq ? rd_q : windex_q;
    wdata_d  = wreq ? res : wdata_q;
  end
  assign bus.busy   = busy;
  assign bus.wreq   = wreq;
  assign bus.windex = windex_d;
  assign bus.wdata  = wdata_d;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed RV32M cases plus random ops against an arithmetic reference model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  muldiv_if bus();
  muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    int              q, r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    up  = {32'd0, a} * {32'd0, b};
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    q   = 0;
    r   = 0;
    if (b != 0 && !ovf) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    p = f == 3'd2 ? sa * longint'({32'd0, b}) : (f == 3'd3 ? longint'(up) : sa * sb);
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : q);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : (ovf ? 32'd0 : r);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  // Starts at a negedge; returns at the negedge before edge 34 so a follow-on start lands in cycle 34
  task automatic run_op(input string tag, input logic [2:0] f, input logic [3:0] r,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input bit stray);
    logic [33:0] bmask, wmask;
    logic [3:0]  wi;
    logic [31:0] wd;
    bmask = '0;
    wmask = '0;
    wi = '0;
    wd = '0;
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.rd = r;
    bus.rs1_val = a;
    bus.rs2_val = b;
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      bmask[k-1] = bus.busy;
      wmask[k-1] = bus.wreq;
      if (bus.wreq) begin
        wi = bus.windex;
        wd = bus.wdata;
      end
      bus.start = stray && (k == 5 || k == 20);
      if (k == 1 || bus.start) begin
        bus.funct3 = 3'($urandom);
        bus.rd = 4'($urandom);
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
      end
    end
    check({tag, " busy"}, 64'(bmask), 64'(34'h1_FFFF_FFFF));
    check({tag, " wreq"}, 64'(wmask), r != 0 ? 64'(34'h1_0000_0000) : 64'd0);
    if (r != 0) begin
      check({tag, " windex"}, 64'(wi), 64'(r));
      check({tag, " wdata"}, 64'(wd), 64'(exp));
    end
  endtask

  initial begin
    int wcnt;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [31:0] corners [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
    bus.start = 1'b0;
    bus.funct3 = '0;
    bus.rd = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    #1 rst = 1'b1;
    #2;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst wreq", 64'(bus.wreq), 64'd0);
    check("rst windex", 64'(bus.windex), 64'd0);
    check("rst wdata", 64'(bus.wdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("mul", 3'd0, 4'd5, 32'd7, -32'sd3, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh", 3'd1, 4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("mulhsu", 3'd2, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("mulhu", 3'd3, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op("div", 3'd4, 4'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run_op("rem", 3'd6, 4'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("divu", 3'd5, 4'd7, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu", 3'd7, 4'd8, 32'd100, 32'd7, 32'd2, 1'b1);
    run_op("div0", 3'd4, 4'd9, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("remu0", 3'd7, 4'd10, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("divovf", 3'd4, 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("removf", 3'd6, 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("rd0", 3'd0, 4'd0, 32'd9, 32'd9, 32'd81, 1'b1);
    bus.start = 1'b1;
    bus.funct3 = 3'd4;
    bus.rd = 4'd3;
    bus.rs1_val = 32'd1000;
    bus.rs2_val = 32'd7;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort wreq", 64'(bus.wreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      wcnt += int'(bus.wreq);
    end
    check("abort nowrite", 64'(wcnt), 64'd0);
    run_op("post rst mulhu", 3'd3, 4'd13, 32'd3, 32'd5, 32'd0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom);
      a = $urandom_range(0, 3) == 0 ? corners[$urandom_range(0, 3)] : $urandom;
      b = $urandom_range(0, 3) == 0 ? corners[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 9));
      run_op($sformatf("rand%0d f%0d", n, f), f, 4'($urandom), a, b, model(f, a, b), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
